ps2_scan_rx: RTL and testbench

PS2_SCAN_RX -- requirements
Module: ps2_scan_rx

---
 rtl/ps2_scan_rx.sv | 204 ++++++++++++++++++++
 tb/tb_ps2_scan_rx.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: synchronises and deglitches the PS/2 lines, frames
// 11-bit serial bytes, folds E0/F0 prefixes into flags and queues decoded
// scan codes in a first-word fall-through FIFO with sticky error flags.
//
// state  | meaning
// IDLE   | waiting for a start bit (sampled 0)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | checking the stop bit, then judging the byte
module ps2_scan_rx #(
  parameter int FIFO_DEPTH  = 8,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          PS2_clk,
  input  logic                          PS2_dat,
  output logic [7:0]                    key_code,
  output logic                          key_rel,
  output logic                          key_ext,
  output logic                          key_valid,
  input  logic                          key_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [2:0]                    err_out,
  input  logic                          err_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          sample;
  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          good, discard, err_par, err_frm;
  logic          brk_q, brk_d, ext_q, ext_d;
  logic          push, pop, full, wr_en, ovf;
  logic [9:0]    push_data;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [2:0]    err_q, err_d;
  logic [9:0]    mem_q [FIFO_DEPTH];

  // Clock filter: flip only after FILTER_LEN consecutive opposite-level cycles;
  // a 1->0 flip is the sample event.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    sample     = 1'b0;
    if (clk_s2_q != filt_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d = clk_s2_q;
        sample = filt_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  // Frame FSM next state, inter-edge timeout down-counter, byte judgement.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tmo_d     = tmo_q;
    good      = 1'b0;
    discard   = 1'b0;
    err_par   = 1'b0;
    err_frm   = 1'b0;
    if (sample) begin
      tmo_d = TW'(TIMEOUT_CYC - 1);
      unique case (state_q)
        IDLE: begin
          if (!dat_s2_q) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat_s2_q;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          err_frm = ~dat_s2_q;
          err_par = ~(^{shift_q, par_q});
          discard = err_frm | err_par;
          good    = ~discard;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (tmo_q == '0) begin
        state_d = IDLE;
        err_frm = 1'b1;
        discard = 1'b1;
      end else begin
        tmo_d = tmo_q - 1'b1;
      end
    end
  end

  // Prefix decode: F0/E0 arm flags, anything else becomes a FIFO entry.
  always_comb begin
    brk_d     = brk_q;
    ext_d     = ext_q;
    push      = 1'b0;
    push_data = {ext_q, brk_q, shift_q};
    if (discard) begin
      brk_d = 1'b0;
      ext_d = 1'b0;
    end else if (good) begin
      if (shift_q == 8'hF0) begin
        brk_d = 1'b1;
      end else if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else begin
        push  = 1'b1;
        brk_d = 1'b0;
        ext_d = 1'b0;
      end
    end
  end

  // FIFO bookkeeping; a pop frees the slot for a same-cycle push when full.
  always_comb begin
    pop      = (level_q != '0) && key_ready;
    full     = (level_q == LW'(FIFO_DEPTH));
    wr_en    = push && (!full || pop);
    ovf      = push && full && !pop;
    rd_ptr_d = rd_ptr_q + AW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    level_d  = level_q + LW'(wr_en) - LW'(pop);
    err_d    = (err_clr ? 3'b000 : err_q) | {ovf, err_frm, err_par};
  end

  // All control state, with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      brk_q      <= 1'b0;
      ext_q      <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      err_q      <= '0;
    end else begin
      clk_s1_q   <= PS2_clk;
      clk_s2_q   <= clk_s1_q;
      dat_s1_q   <= PS2_dat;
      dat_s2_q   <= dat_s1_q;
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      brk_q      <= brk_d;
      ext_q      <= ext_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      err_q      <= err_d;
    end
  end

  // Storage array needs no reset; the head is masked while empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data;
  end

  assign key_valid                    = (level_q != '0);
  assign {key_ext, key_rel, key_code} = key_valid ? mem_q[rd_ptr_q] : 10'd0;
  assign fifo_level                   = level_q;
  assign err_out                      = err_q;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Directed bench for ps2_scan_rx: serial frames driven on the PS/2 lines,
// outputs compared against hand-computed values.
module tb_ps2_scan_rx;

  localparam int DEPTH = 4;
  localparam int FLEN  = 4;
  localparam int TMO   = 300;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       PS2_clk = 1'b1;
  logic       PS2_dat = 1'b1;
  logic [7:0] key_code;
  logic       key_rel, key_ext, key_valid;
  logic       key_ready = 1'b0;
  logic [2:0] fifo_level;
  logic [2:0] err_out;
  logic       err_clr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  ps2_scan_rx #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FLEN), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .PS2_clk(PS2_clk), .PS2_dat(PS2_dat),
    .key_code(key_code), .key_rel(key_rel), .key_ext(key_ext),
    .key_valid(key_valid), .key_ready(key_ready), .fifo_level(fifo_level),
    .err_out(err_out), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk) PS2_dat = b;
    repeat (10) @(negedge clk);
    PS2_clk = 1'b0;
    repeat (20) @(negedge clk);
    PS2_clk = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(~(^d) ^ bad_par);
    send_bit(1'b1);
    repeat (5) @(negedge clk);
  endtask

  task automatic pop_one();
    @(negedge clk) key_ready = 1'b1;
    @(negedge clk) key_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
  endtask

  initial begin
    logic [7:0] codes [5];
    codes[0] = 8'h16; codes[1] = 8'h1E; codes[2] = 8'h26; codes[3] = 8'h25; codes[4] = 8'h2E;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_valid", key_valid, 0);
    check("rst_level", fifo_level, 0);
    check("rst_code", key_code, 0);
    check("rst_err", err_out, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // make, break of same key
    send_frame(8'h25, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h25, 0);
    check("s1_level", fifo_level, 2);
    check("s1_code0", key_code, 8'h25);
    check("s1_rel0", key_rel, 0);
    check("s1_ext0", key_ext, 0);
    pop_one();
    check("s1_code1", key_code, 8'h25);
    check("s1_rel1", key_rel, 1);
    check("s1_level1", fifo_level, 1);
    pop_one();
    check("s1_valid_empty", key_valid, 0);

    // extended break
    send_frame(8'hE0, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h5A, 0);
    check("s2_level", fifo_level, 1);
    check("s2_code", key_code, 8'h5A);
    check("s2_ext", key_ext, 1);
    check("s2_rel", key_rel, 1);
    pop_one();

    // ready while empty is ignored
    @(negedge clk) key_ready = 1'b1;
    repeat (3) @(negedge clk);
    key_ready = 1'b0;
    check("empty_pop_level", fifo_level, 0);
    check("empty_pop_valid", key_valid, 0);

    // parity error discards byte and pending break flag
    send_frame(8'hF0, 0);
    send_frame(8'h1C, 1);
    check("s3_level", fifo_level, 0);
    check("s3_err", err_out, 3'b001);
    send_frame(8'h1C, 0);
    check("s3_code", key_code, 8'h1C);
    check("s3_rel_cleared", key_rel, 0);
    pop_one();
    pulse_clr();
    check("s3_err_clr", err_out, 0);

    // overflow
    for (int i = 0; i < DEPTH + 1; i++) send_frame(codes[i], 0);
    check("s4_level", fifo_level, DEPTH);
    check("s4_err", err_out, 3'b100);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("s4_order%0d", i), key_code, codes[i]);
      pop_one();
    end
    check("s4_last_absent", key_valid, 0);
    pulse_clr();

    // timeout after 4 data bits
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    repeat (TMO + 100) @(negedge clk);
    check("s5_err", err_out, 3'b010);
    check("s5_level", fifo_level, 0);
    pulse_clr();
    send_frame(8'h45, 0);
    check("s5_code", key_code, 8'h45);
    check("s5_level1", fifo_level, 1);
    check("s5_err_clean", err_out, 0);
    pop_one();

    // short clock glitch with data low must not start a frame
    @(negedge clk) PS2_dat = 1'b0;
    PS2_clk = 1'b0;
    repeat (2) @(negedge clk);
    PS2_clk = 1'b1;
    repeat (20) @(negedge clk);
    PS2_dat = 1'b1;
    send_frame(8'h29, 0);
    check("s6_glitch_err", err_out, 0);
    check("s6_glitch_code", key_code, 8'h29);
    check("s6_glitch_level", fifo_level, 1);

    // mid-frame reset with an entry queued and an error set
    send_frame(8'h29, 1);
    check("s6_pre_err", err_out, 3'b001);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("s6_rst_valid", key_valid, 0);
    check("s6_rst_level", fifo_level, 0);
    check("s6_rst_code", key_code, 0);
    check("s6_rst_err", err_out, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(8'h3C, 0);
    check("s6_after_code", key_code, 8'h3C);
    check("s6_after_level", fifo_level, 1);
    check("s6_after_flags", {key_ext, key_rel}, 0);
    check("s6_after_err", err_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
